// File: rtl/rf80386_prefetchq_if.sv
// Code-fetch bus between the prefetch queue (master) and memory (slave).
// Byte-wide, read-only, single outstanding cycle terminated by ack or err.
interface rf80386_prefetchq_if #(
    parameter int AW = 20
);
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [7:0]    dat_i;
    logic          ack_i;
    logic          err_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/rf80386_prefetchq.sv
// rf80386 code-byte prefetch queue: fetches sequential code bytes ahead of
// the decoder into a circular FIFO; a flush restarts fetching elsewhere.
//
// state | meaning
// IDLE  | no bus cycle; start one when enabled and a slot is free
// FETCH | read outstanding at fa, waiting for ack/err
// FAULT | bus error at fa; no more reads until flush or reset
module rf80386_prefetchq #(
    parameter int            DEPTH   = 16,
    parameter int            AW      = 20,
    parameter logic [AW-1:0] RST_ADR = 'hFFFF0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       flush_i,
    input  logic [AW-1:0]              flush_adr_i,
    input  logic                       q_take_i,
    output logic                       q_rdy_o,
    output logic [7:0]                 q_byte_o,
    output logic [AW-1:0]              q_adr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       flt_o,
    rf80386_prefetchq_if.master        bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [AW-1:0]   fa;
    logic [AW-1:0]   head_adr;
    logic [AW-1:0]   adr_r;
    logic            cyc_r;
    logic            stb_r;
    logic            take;
    logic            ack_ev;
    logic            err_ev;

    // Qualified events: err wins over ack, take only with a valid head.
    always_comb begin
        take      = q_take_i && (count != '0);
        ack_ev    = (state == FETCH) && bus.ack_i && !bus.err_i;
        err_ev    = (state == FETCH) && bus.err_i;
        count_nxt = count + CW'(ack_ev) - CW'(take);
    end

    // Byte storage; a flush discards the ack arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && ack_ev)
            mem[wr_ptr] <= bus.dat_i;
    end

    // Fetch FSM, pointers, occupancy and head/fetch address tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fa       <= RST_ADR;
            head_adr <= RST_ADR;
            adr_r    <= '1;
            cyc_r    <= 1'b0;
            stb_r    <= 1'b0;
        end else if (flush_i) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fa       <= flush_adr_i;
            head_adr <= flush_adr_i;
            cyc_r    <= 1'b0;
            stb_r    <= 1'b0;
        end else begin
            count <= count_nxt;
            if (take) begin
                rd_ptr   <= rd_ptr + PW'(1);
                head_adr <= head_adr + AW'(1);
            end
            if (ack_ev) begin
                wr_ptr <= wr_ptr + PW'(1);
                fa     <= fa + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (en_i && (count < CW'(DEPTH))) begin
                        state <= FETCH;
                        cyc_r <= 1'b1;
                        stb_r <= 1'b1;
                        adr_r <= fa;
                    end
                end
                FETCH: begin
                    if (err_ev) begin
                        state <= FAULT;
                        cyc_r <= 1'b0;
                        stb_r <= 1'b0;
                    end else if (ack_ev) begin
                        adr_r <= fa + AW'(1);
                        if (!(en_i && (count_nxt < CW'(DEPTH)))) begin
                            state <= IDLE;
                            cyc_r <= 1'b0;
                            stb_r <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    cyc_r <= 1'b0;
                    stb_r <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cyc_r <= 1'b0;
                    stb_r <= 1'b0;
                end
            endcase
        end
    end

    assign q_rdy_o   = (count != '0);
    assign q_byte_o  = mem[rd_ptr];
    assign q_adr_o   = head_adr;
    assign count_o   = count;
    assign flt_o     = (state == FAULT) && (count == '0);
    assign bus.cyc_o = cyc_r;
    assign bus.stb_o = stb_r;
    assign bus.we_o  = 1'b0;
    assign bus.adr_o = adr_r;
endmodule

// File: tb/tb_rf80386_prefetchq.sv
// Bench for rf80386_prefetchq: memory model returns the low address byte,
// a scoreboard holds expected {address, byte} pairs popped on every take.
module tb_rf80386_prefetchq;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic [19:0] flush_adr;
    logic        take;
    logic        q_rdy;
    logic [7:0]  q_byte;
    logic [19:0] q_adr;
    logic [4:0]  count;
    logic        flt;

    int          checks = 0;
    int          errors = 0;
    logic [27:0] sb [$];

    int          wait_n = 0;
    int          wcnt = 0;
    bit          err_en = 1'b0;
    logic [19:0] err_adr = '0;

    rf80386_prefetchq_if #(.AW(20)) bus ();

    rf80386_prefetchq #(.DEPTH(16), .AW(20), .RST_ADR(20'hFFFF0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .flush_i     (flush),
        .flush_adr_i (flush_adr),
        .q_take_i    (take),
        .q_rdy_o     (q_rdy),
        .q_byte_o    (q_byte),
        .q_adr_o     (q_adr),
        .count_o     (count),
        .flt_o       (flt),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    // Memory slave: wait_n wait states, data = low address byte, optional err.
    initial begin
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.dat_i = 8'h00;
    end
    always @(posedge clk) begin
        #1;
        if (bus.ack_i || bus.err_i) wcnt = 0;
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        if (bus.cyc_o && bus.stb_o) begin
            if (wcnt >= wait_n) begin
                if (err_en && bus.adr_o == err_adr) begin
                    bus.err_i = 1'b1;
                end else begin
                    bus.ack_i = 1'b1;
                    bus.dat_i = bus.adr_o[7:0];
                end
            end else begin
                wcnt = wcnt + 1;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: every accepted take must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && !flush && take && q_rdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL take_unexpected: got adr=%05h byte=%02h, none expected", q_adr, q_byte);
            end else begin
                logic [27:0] e;
                e = sb.pop_front();
                if (q_adr !== e[27:8] || q_byte !== e[7:0]) begin
                    errors++;
                    $display("FAIL take_data: got adr=%05h byte=%02h, expected adr=%05h byte=%02h",
                             q_adr, q_byte, e[27:8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [19:0] a, input int n);
        logic [19:0] t;
        for (int i = 0; i < n; i++) begin
            t = a + 20'(i);
            sb.push_back({t, t[7:0]});
        end
    endtask

    task automatic do_flush(input logic [19:0] a);
        flush = 1'b1;
        flush_adr = a;
        sb.delete();
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; flush = 1'b0; flush_adr = '0; take = 1'b0;
        repeat (3) tick();
        chk("rst_cyc", bus.cyc_o, 0);
        chk("rst_stb", bus.stb_o, 0);
        chk("rst_we", bus.we_o, 0);
        chk("rst_adr", bus.adr_o, 20'hFFFFF);
        chk("rst_rdy", q_rdy, 0);
        chk("rst_count", count, 0);
        chk("rst_flt", flt, 0);
        chk("rst_qadr", q_adr, 20'hFFFF0);

        // Fill to full from reset address, wrap of fetch address.
        push_exp(20'hFFFF0, 16);
        en = 1'b1; rst = 1'b0;
        n = 0; while (!bus.stb_o && n < 10) begin tick(); n++; end
        chk("fill_first_stb", bus.stb_o, 1);
        chk("fill_first_adr", bus.adr_o, 20'hFFFF0);
        n = 0; while (count != 16 && n < 40) begin tick(); n++; end
        chk("fill_count", count, 16);
        chk("fill_stb_drop", bus.stb_o, 0);
        chk("fill_adr_wrap", bus.adr_o, 20'h00000);
        repeat (3) tick();
        chk("full_stb", bus.stb_o, 0);
        chk("full_count", count, 16);
        en = 1'b0; take = 1'b1;
        repeat (16) tick();
        take = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_rdy", q_rdy, 0);
        chk("drain_qadr", q_adr, 20'h00000);

        // Streaming: take every cycle with zero-wait memory.
        en = 1'b1;
        do_flush(20'h00100);
        push_exp(20'h00100, 40);
        take = 1'b1;
        n = 0; while (count != 1 && n < 10) begin tick(); n++; end
        chk("stream_reach1", count, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stream_count", count, 1);
            chk("stream_stb", bus.stb_o, 1);
        end
        take = 1'b0; en = 1'b0;
        repeat (3) tick();

        // Flush while ack for FFFF5 arrives in the same cycle.
        en = 1'b1;
        do_flush(20'hFFFF0);
        n = 0; while (!(bus.stb_o && bus.adr_o == 20'hFFFF5) && n < 20) begin tick(); n++; end
        chk("fl_at_fff5", bus.adr_o, 20'hFFFF5);
        do_flush(20'h01234);
        push_exp(20'h01234, 2);
        chk("fl_count", count, 0);
        chk("fl_rdy", q_rdy, 0);
        chk("fl_qadr", q_adr, 20'h01234);
        n = 0; while (!bus.stb_o && n < 10) begin tick(); n++; end
        chk("fl_new_adr", bus.adr_o, 20'h01234);
        n = 0; while (count < 2 && n < 10) begin tick(); n++; end
        en = 1'b0; take = 1'b1;
        repeat (2) tick();
        take = 1'b0;

        // Bus error at 0x00010 with three bytes queued ahead of it.
        err_adr = 20'h00010; err_en = 1'b1; en = 1'b1;
        do_flush(20'h0000D);
        push_exp(20'h0000D, 3);
        n = 0; while (count != 3 && n < 10) begin tick(); n++; end
        repeat (3) tick();
        chk("err_stb", bus.stb_o, 0);
        chk("err_count", count, 3);
        chk("err_flt_early", flt, 0);
        take = 1'b1;
        tick(); tick();
        chk("err_flt_1left", flt, 0);
        tick();
        take = 1'b0;
        chk("err_flt", flt, 1);
        chk("err_stb_late", bus.stb_o, 0);
        err_en = 1'b0;
        do_flush(20'h00020);
        chk("err_flush_flt", flt, 0);
        n = 0; while (!bus.stb_o && n < 10) begin tick(); n++; end
        chk("err_resume_adr", bus.adr_o, 20'h00020);
        en = 1'b0;
        repeat (3) tick();

        // en dropped mid-cycle against a 2-wait slave.
        wait_n = 2; en = 1'b1;
        do_flush(20'h00040);
        push_exp(20'h00040, 2);
        n = 0; while (!bus.stb_o && n < 10) begin tick(); n++; end
        en = 1'b0;
        n = 0; while (count != 1 && n < 10) begin tick(); n++; end
        chk("en_count", count, 1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.stb_o) n++;
            tick();
        end
        chk("en_no_stb", n, 0);
        chk("en_count_hold", count, 1);
        en = 1'b1;
        n = 0; while (!bus.stb_o && n < 10) begin tick(); n++; end
        chk("en_resume_adr", bus.adr_o, 20'h00041);
        en = 1'b0;
        n = 0; while (count != 2 && n < 10) begin tick(); n++; end
        take = 1'b1;
        repeat (2) tick();
        take = 1'b0;

        // Take and ack in the same cycle at count 5.
        wait_n = 0; en = 1'b1;
        do_flush(20'h00080);
        push_exp(20'h00080, 6);
        n = 0; while (count != 5 && n < 20) begin tick(); n++; end
        chk("ta_reach5", count, 5);
        take = 1'b1; en = 1'b0;
        tick();
        chk("ta_count", count, 5);
        chk("ta_stb", bus.stb_o, 0);
        repeat (5) tick();
        take = 1'b0;
        chk("ta_drain", count, 0);
        chk("ta_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
